// File: rtl/bpu_hist_queue.sv
// Speculative/commit global history plus in-flight prediction FIFO feeding the choice PHT; upd_* one cycle after resolve.
// pred_ready drops when full, a mispredicting resolve flushes the queue; BPU_HIST_QUEUE_STAT_EN adds stat counters.
module bpu_hist_queue #(
  parameter int GHR_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stallreq,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_b,
  input  logic                     pred_g,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  output logic [GHR_W-1:0]         pht_addr,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic [GHR_W-1:0]         upd_addr,
  output logic                     upd_b_ok,
  output logic                     upd_g_ok,
  output logic                     mispredict,
`ifdef BPU_HIST_QUEUE_STAT_EN
  output logic [15:0]              stat_mispred,
  output logic [15:0]              stat_disagree,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [GHR_W-1:0] addr;
    logic             b;
    logic             g;
    logic             t;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW:0]      r_head, r_tail;
  logic [GHR_W-1:0] r_spec_ghr, r_commit_ghr;
  logic             r_upd_valid, r_mispredict, r_upd_b_ok, r_upd_g_ok;
  logic [GHR_W-1:0] r_upd_addr;

  logic [AW:0]      w_occ;
  logic             w_push, w_pop, w_mis;
  entry_t           w_head_ent, w_new_ent;
  logic [GHR_W-1:0] w_pht_addr;
  logic [GHR_W+3:0] w_unused_pc;

  // Pointer difference modulo 2*DEPTH gives 0..DEPTH directly.
  assign w_occ      = r_tail - r_head;
  assign w_pht_addr = pred_pc[GHR_W+1:2] ^ r_spec_ghr;
  assign w_unused_pc = {pred_pc[31:GHR_W+2], pred_pc[1:0]};

  assign pred_ready = (w_occ != DEPTH[AW:0]);
  assign w_push     = pred_valid & pred_ready & ~stallreq;
  assign w_pop      = resolve_valid & ~stallreq & (w_occ != '0);
  assign w_head_ent = r_mem[r_head[AW-1:0]];
  assign w_mis      = w_pop & (w_head_ent.t != resolve_taken);
  assign w_new_ent  = '{addr: w_pht_addr, b: pred_b, g: pred_g, t: pred_taken};

  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_mis) begin
      r_mem[r_tail[AW-1:0]] <= w_new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_spec_ghr   <= '0;
      r_commit_ghr <= '0;
      r_upd_valid  <= 1'b0;
      r_mispredict <= 1'b0;
      r_upd_addr   <= '0;
      r_upd_b_ok   <= 1'b0;
      r_upd_g_ok   <= 1'b0;
    end else begin
      r_upd_valid  <= w_pop;
      r_mispredict <= w_mis;
      if (w_pop) begin
        r_head       <= r_head + 1'b1;
        r_commit_ghr <= {r_commit_ghr[GHR_W-2:0], resolve_taken};
        r_upd_addr   <= w_head_ent.addr;
        r_upd_b_ok   <= (w_head_ent.b == resolve_taken);
        r_upd_g_ok   <= (w_head_ent.g == resolve_taken);
      end
      // Repair wins over any same-cycle push: younger entries and the push are wrong-path.
      if (w_mis) begin
        r_spec_ghr <= {r_commit_ghr[GHR_W-2:0], resolve_taken};
        r_tail     <= r_head + 1'b1;
      end else if (w_push) begin
        r_spec_ghr <= {r_spec_ghr[GHR_W-2:0], pred_taken};
        r_tail     <= r_tail + 1'b1;
      end
    end
  end

`ifdef BPU_HIST_QUEUE_STAT_EN
  logic [15:0] r_stat_mispred, r_stat_disagree;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_mispred  <= '0;
      r_stat_disagree <= '0;
    end else begin
      if (w_mis && r_stat_mispred != 16'hFFFF) begin
        r_stat_mispred <= r_stat_mispred + 16'd1;
      end
      if (w_pop && (w_head_ent.b != w_head_ent.g) && r_stat_disagree != 16'hFFFF) begin
        r_stat_disagree <= r_stat_disagree + 16'd1;
      end
    end
  end

  assign stat_mispred  = r_stat_mispred;
  assign stat_disagree = r_stat_disagree;
`endif

  assign pht_addr   = w_pht_addr;
  assign upd_valid  = r_upd_valid;
  assign upd_addr   = r_upd_addr;
  assign upd_b_ok   = r_upd_b_ok;
  assign upd_g_ok   = r_upd_g_ok;
  assign mispredict = r_mispredict;
  assign occupancy  = w_occ;

endmodule

// File: doc/bpu_hist_queue.md
# bpu_hist_queue

Global-history and in-flight prediction tracker for the tournament branch predictor. It sits directly upstream of the choice PHT. It computes the chooser index from the fetch PC and the speculative global history. It records every issued prediction in a FIFO and, when a branch resolves, produces the registered update for the chooser: valid, index, and which sub-predictor was right. On a misprediction it repairs the speculative history and discards younger entries.

## Interface
- `GHR_W`, default 8: global history width; also the chooser index width.
- `DEPTH`, default 8: in-flight FIFO entries; must be a power of 2, at least 2.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `stallreq`, input, 1: pipeline stall; freezes all state.
- `pred_valid`, input, 1: a branch is predicted this cycle.
- `pred_pc`, input, 32: PC of the predicted branch.
- `pred_b`, input, 1: bimodal direction.
- `pred_g`, input, 1: gshare direction.
- `pred_taken`, input, 1: final chosen direction.
- `pred_ready`, output, 1: FIFO can accept a push.
- `pht_addr`, output, GHR_W: chooser index, `pred_pc[GHR_W+1:2] ^ spec_ghr`.
- `resolve_valid`, input, 1: the oldest in-flight branch resolved in EX.
- `resolve_taken`, input, 1: actual direction.
- `upd_valid`, output, 1: chooser update strobe.
- `upd_addr`, output, GHR_W: chooser index of the resolved branch.
- `upd_b_ok`, output, 1: bimodal prediction was correct.
- `upd_g_ok`, output, 1: gshare prediction was correct.
- `mispredict`, output, 1: the final direction was wrong (registered).
- `occupancy`, output, log2(DEPTH)+1: number of valid entries.

## Operation
- State:
  - `spec_ghr` and `commit_ghr`, each GHR_W bits.
  - FIFO with head/tail pointers of log2(DEPTH)+1 bits, where the extra MSB distinguishes full from empty.
  - Each entry holds {addr, pred_b, pred_g, pred_taken}.
- Push:
  - Occurs when `pred_valid & pred_ready & ~stallreq`.
  - Writes {pht_addr, pred_b, pred_g, pred_taken} at tail; tail increments.
  - `spec_ghr <= {spec_ghr[GHR_W-2:0], pred_taken}`.
- Pop:
  - Occurs when `resolve_valid & ~stallreq & occupancy!=0`; head increments.
  - `commit_ghr <= {commit_ghr[GHR_W-2:0], resolve_taken}`.
  - `upd_addr <= entry.addr`.
  - `upd_b_ok <= entry.pred_b==resolve_taken`.
  - `upd_g_ok <= entry.pred_g==resolve_taken`.
  - `upd_valid <= 1`.
  - `mispredict <= entry.pred_taken!=resolve_taken`.
- Misprediction repair, on the same edge as the pop:
  - `spec_ghr <= {commit_ghr[GHR_W-2:0], resolve_taken}`.
  - tail <= new head, which empties the FIFO.
  - A push in the same cycle is dropped.
- Correct pop with a simultaneous push: both take effect; occupancy is unchanged.
- Resolve with an empty FIFO: ignored; `upd_valid` stays 0; no state changes.
- Push when full: `pred_ready`=0, so the push is ignored and `spec_ghr` is unchanged.
- Wrap-around: pointers wrap modulo 2·DEPTH. Full means the indices are equal and the MSBs differ.

## Timing
- Combinational outputs:
  - `pht_addr` is valid in the same cycle as `pred_pc`.
  - `pred_ready` = `occupancy != DEPTH`.
- `upd_*` and `mispredict` are registered one cycle after the resolve edge.
- `upd_valid` and `mispredict` are single-cycle pulses; they are 0 in any cycle without a pop.
- `stallreq`=1:
  - No push or pop.
  - `upd_valid` and `mispredict` are forced to 0 on the next edge.
  - `upd_addr`, `upd_b_ok` and `upd_g_ok` hold their values.
- Reset values:
  - `upd_valid`=0, `mispredict`=0, `upd_addr`=0, `upd_b_ok`=0, `upd_g_ok`=0.
  - `occupancy`=0, both GHRs=0, pointers=0.
  - Therefore `pred_ready`=1 and `pht_addr`=`pred_pc[GHR_W+1:2]`.
- Reset asserted mid-operation clears all state on that edge and overrides any push or resolve.

## Configuration
- `BPU_HIST_QUEUE_STAT_EN` defined:
  - Adds output `stat_mispred` (16) and output `stat_disagree` (16).
  - Both are saturating counters, reset to 0 and frozen by `stallreq`.
  - `stat_mispred` increments on every pop with a misprediction.
  - `stat_disagree` increments on every pop where `pred_b != pred_g`.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then push PC=0x400 (taken): `pht_addr`=0x00 in the push cycle and `spec_ghr`=0x01 afterwards. A second push at PC=0x404 shows `pht_addr`=0x01^0x01=0x00.
- Push 8 entries without resolving: `pred_ready`=0 and `occupancy`=8. A 9th push is ignored and `spec_ghr` is unchanged.
- Push entry {b=1, g=0, taken=1}, resolve taken: one cycle later `upd_valid`=1, `upd_b_ok`=1, `upd_g_ok`=0, `mispredict`=0.
- Push 3 entries, then resolve the oldest with a wrong direction while pushing: `occupancy`=0, the push is dropped, `spec_ghr`={commit_ghr<<1, actual}, `mispredict`=1.
- Resolve on an empty FIFO, and assert `stallreq` during a resolve: no `upd_valid` in either case and no state change. Assert `rst` mid-stream: all outputs return to their reset values on the next edge.
- With `BPU_HIST_QUEUE_STAT_EN` defined: 2 mispredicts and 3 disagreements give `stat_mispred`=2 and `stat_disagree`=3. Forcing 0xFFFF+1 holds at 0xFFFF.
